// File: rtl/change_payout_ctrl.sv
// rtl/change_payout_ctrl.sv - paced big/small coin change payout sequencer
//
// Purpose: latches the change owed after a purchase or cancel and pays it out
// as a series of big-coin and small-coin pulses. Each pulse and each idle gap
// is timed in tick strobes. The undelivered remainder is reported for the
// money display.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   tick       in   1-cycle enable strobe from the tick divider
//   start      in   1-cycle request to begin payout of amount (IDLE only)
//   amount     in   money to return, sampled when start is accepted
//   abort      in   level; stop payout after the current coin
//   coin_big   out  high while a big coin is being paid
//   coin_small out  high while a small coin is being paid
//   remaining  out  money not yet paid
//   busy       out  high from accept until done
//   done       out  1-cycle pulse at end of payout
//   aborted    out  set with done when ended by abort, held until next accept
module change_payout_ctrl #(
    parameter int W           = 8,
    parameter int BIG_VAL     = 10,
    parameter int SMALL_VAL   = 1,
    parameter int PULSE_TICKS = 2,
    parameter int GAP_TICKS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start,
    input  logic [W-1:0] amount,
    input  logic         abort,
    output logic         coin_big,
    output logic         coin_small,
    output logic [W-1:0] remaining,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [W-1:0]  BIG        = W'(BIG_VAL);
    localparam logic [W-1:0]  SMALL      = W'(SMALL_VAL);

    // With no gap configured a finished pulse goes straight back to SELECT.
    localparam state_t AFTER_PULSE = (GAP_TICKS > 0) ? S_GAP : S_SELECT;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          abort_hold;
    logic [W-1:0]  coin_val;

    // Value of the coin currently being paid; only meaningful in PULSE.
    assign coin_val = coin_big ? BIG : SMALL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            abort_hold <= 1'b0;
            coin_big   <= 1'b0;
            coin_small <= 1'b0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort is deliberately not looked at here
                    if (start) begin
                        remaining  <= amount;
                        aborted    <= 1'b0;
                        abort_hold <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    cnt <= '0;
                    if (abort || abort_hold) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else if (remaining >= BIG) begin
                        coin_big <= 1'b1;
                        state    <= S_PULSE;
                    end else if (remaining >= SMALL) begin
                        coin_small <= 1'b1;
                        state      <= S_PULSE;
                    end else begin
                        // residual below the small coin stays in remaining
                        state <= S_DONE;
                    end
                end

                S_PULSE: begin
                    // a pulse is never cut short; remember abort for SELECT
                    if (abort) begin
                        abort_hold <= 1'b1;
                    end
                    if (tick) begin
                        if (cnt == PULSE_LAST) begin
                            coin_big   <= 1'b0;
                            coin_small <= 1'b0;
                            if (coin_val <= remaining) begin
                                remaining <= remaining - coin_val;
                            end
                            cnt   <= '0;
                            state <= AFTER_PULSE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else if (tick) begin
                        if (cnt == GAP_LAST) begin
                            cnt   <= '0;
                            state <= S_SELECT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    abort_hold <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_payout_ctrl.sv
// tb/tb_change_payout_ctrl.sv - directed self-checking bench for change_payout_ctrl
module tb_change_payout_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       abort;
    logic       start1, start2;
    logic [7:0] amount1, amount2;
    logic       cb1, cs1, busy1, done1, ab1;
    logic       cb2, cs2, busy2, done2, ab2;
    logic [7:0] rem1, rem2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    int n_big, n_small, n_done, gap_ticks, overlap, ab_at_done, rem_idx;
    int exp_rem[$];

    always #5 clk = ~clk;

    change_payout_ctrl dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start1), .amount(amount1),
        .abort(abort), .coin_big(cb1), .coin_small(cs1), .remaining(rem1),
        .busy(busy1), .done(done1), .aborted(ab1)
    );

    change_payout_ctrl #(.W(8), .BIG_VAL(4), .SMALL_VAL(2), .PULSE_TICKS(2), .GAP_TICKS(1)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start2), .amount(amount2),
        .abort(abort), .coin_big(cb2), .coin_small(cs2), .remaining(rem2),
        .busy(busy2), .done(done2), .aborted(ab2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one clock; sample point and input updates sit 1 time unit after
    // the edge; tick is high one cycle in four
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        tick = (cyc_n % 4 == 0);
    endtask

    // Runs a payout already requested by the caller until done or timeout,
    // checking coin values, pulse widths and remaining at every coin start.
    task automatic run(input int which, input int max_cyc, input bit do_abort, input bit do_restart);
        logic cb, cs, pcb, pcs, bz, dn;
        logic [7:0] rem;
        int w;
        bit saw_coin;
        n_big = 0; n_small = 0; n_done = 0; gap_ticks = 0; overlap = 0;
        ab_at_done = 0; rem_idx = 0; w = 0; saw_coin = 0;
        pcb = 1'b0; pcs = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            cyc();
            start1 = 1'b0;
            start2 = 1'b0;
            cb  = which ? cb2 : cb1;
            cs  = which ? cs2 : cs1;
            rem = which ? rem2 : rem1;
            bz  = which ? busy2 : busy1;
            dn  = which ? done2 : done1;
            if (cb && cs) overlap++;
            if ((cb && !pcb) || (cs && !pcs)) begin
                if (cb) n_big++; else n_small++;
                if (rem_idx < exp_rem.size())
                    chk("rem_at_coin", 32'(rem), 32'(exp_rem[rem_idx]));
                else
                    chk("extra_coin", 32'(rem_idx), 32'(exp_rem.size()));
                rem_idx++;
                w = 0;
                saw_coin = 1;
                if (do_abort && n_big == 2) abort = 1'b1;
                if (do_restart && rem_idx == 1) begin
                    start1 = 1'b1;
                    amount1 = 8'd99;
                end
            end
            if ((pcb && !cb) || (pcs && !cs)) chk("pulse_ticks", 32'(w), 32'd2);
            if (cb || cs) w += int'(tick);
            else if (saw_coin && bz && tick) gap_ticks++;
            pcb = cb;
            pcs = cs;
            if (dn) begin
                n_done++;
                ab_at_done = int'(which ? ab2 : ab1);
                break;
            end
        end
        chk("done_seen", 32'(n_done), 32'd1);
        chk("coin_overlap", 32'(overlap), 32'd0);
        chk("coins_paid", 32'(rem_idx), 32'(exp_rem.size()));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; abort = 1'b0;
        start1 = 1'b0; start2 = 1'b0; amount1 = '0; amount2 = '0;
        repeat (3) cyc();
        chk("rst_coin_big", 32'(cb1), 32'd0);
        chk("rst_coin_small", 32'(cs1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_aborted", 32'(ab1), 32'd0);
        chk("rst_remaining", 32'(rem1), 32'd0);
        rst = 1'b0;
        cyc();

        // 23 units: two big, three small, 2-tick pulses, 1-tick gaps
        exp_rem = '{23, 13, 3, 2, 1};
        start1 = 1'b1; amount1 = 8'd23;
        run(0, 600, 0, 0);
        chk("t1_big", 32'(n_big), 32'd2);
        chk("t1_small", 32'(n_small), 32'd3);
        chk("t1_gap_ticks", 32'(gap_ticks), 32'd5);
        chk("t1_aborted", 32'(ab_at_done), 32'd0);
        chk("t1_busy_at_done", 32'(busy1), 32'd0);
        chk("t1_remaining", 32'(rem1), 32'd0);
        cyc();
        chk("t1_done_once", 32'(done1), 32'd0);

        // zero amount: done exactly two cycles after the start edge
        start1 = 1'b1; amount1 = 8'd0;
        cyc();
        start1 = 1'b0;
        chk("t2_busy_c0", 32'(busy1), 32'd1);
        chk("t2_done_c0", 32'(done1), 32'd0);
        cyc();
        chk("t2_done_c1", 32'(done1), 32'd0);
        chk("t2_coin_c1", 32'(cb1 | cs1), 32'd0);
        cyc();
        chk("t2_done_c2", 32'(done1), 32'd1);
        chk("t2_busy_c2", 32'(busy1), 32'd0);
        chk("t2_remaining", 32'(rem1), 32'd0);

        // abort while idle does nothing
        abort = 1'b1;
        repeat (3) cyc();
        chk("idle_abort_busy", 32'(busy1), 32'd0);
        chk("idle_abort_aborted", 32'(ab1), 32'd0);

        // start and abort together: start wins, abort gone next cycle
        start1 = 1'b1; amount1 = 8'd0;
        cyc();
        start1 = 1'b0; abort = 1'b0;
        cyc();
        cyc();
        chk("start_abort_done", 32'(done1), 32'd1);
        chk("start_abort_aborted", 32'(ab1), 32'd0);

        // abort raised mid second big pulse
        exp_rem = '{25, 15};
        start1 = 1'b1; amount1 = 8'd25;
        run(0, 600, 1, 0);
        abort = 1'b0;
        chk("t3_big", 32'(n_big), 32'd2);
        chk("t3_small", 32'(n_small), 32'd0);
        chk("t3_aborted", 32'(ab_at_done), 32'd1);
        chk("t3_remaining", 32'(rem1), 32'd5);
        repeat (3) cyc();
        chk("t3_rem_hold", 32'(rem1), 32'd5);
        chk("t3_aborted_hold", 32'(ab1), 32'd1);

        // start re-pulsed while busy is ignored
        exp_rem = '{23, 13, 3, 2, 1};
        start1 = 1'b1; amount1 = 8'd23;
        run(0, 600, 0, 1);
        chk("t4_big", 32'(n_big), 32'd2);
        chk("t4_small", 32'(n_small), 32'd3);
        chk("t4_remaining", 32'(rem1), 32'd0);
        chk("t4_aborted", 32'(ab_at_done), 32'd0);
        cyc();
        chk("t4_no_restart", 32'(busy1), 32'd0);

        // other coin values: 7 = 4 + 2, residual 1
        exp_rem = '{7, 3};
        start2 = 1'b1; amount2 = 8'd7;
        run(1, 600, 0, 0);
        chk("t5_big", 32'(n_big), 32'd1);
        chk("t5_small", 32'(n_small), 32'd1);
        chk("t5_remaining", 32'(rem2), 32'd1);
        chk("t5_aborted", 32'(ab_at_done), 32'd0);

        // reset during a small coin clears outputs without a clock edge
        start1 = 1'b1; amount1 = 8'd3;
        cyc();
        start1 = 1'b0;
        for (int i = 0; i < 40 && !cs1; i++) cyc();
        chk("t6_small_high", 32'(cs1), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_small", 32'(cs1), 32'd0);
        chk("t6_rst_busy", 32'(busy1), 32'd0);
        chk("t6_rst_remaining", 32'(rem1), 32'd0);
        cyc();
        chk("t6_no_done", 32'(done1), 32'd0);
        rst = 1'b0;
        cyc();
        exp_rem = '{2, 1};
        start1 = 1'b1; amount1 = 8'd2;
        run(0, 600, 0, 0);
        chk("t6_small", 32'(n_small), 32'd2);
        chk("t6_remaining", 32'(rem1), 32'd0);
        chk("t6_aborted", 32'(ab_at_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
